// File: rtl/sbox_round_sched.sv
// Time-multiplexed DES S-box sequencer: one 48-bit block -> eight lookups on a shared bank -> 32-bit word.
// Optional synchronous abort port enabled by defining SBOX_SCHED_FLUSH_EN.
module sbox_round_sched #(
  parameter int unsigned LOOKUP_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SBOX_SCHED_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        lk_valid,
  output logic [2:0]  lk_sel,
  output logic [5:0]  lk_addr,
  input  logic [3:0]  lk_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [47:0] blk_q, blk_d;
  logic [31:0] res_q, res_d;
  logic [2:0]  cap_q, cap_d;
  logic        lk_valid_q, lk_valid_d;
  logic [2:0]  lk_sel_q, lk_sel_d;
  logic [5:0]  lk_addr_q, lk_addr_d;
  logic        cap_slot;
  logic        cap_en;
  logic        flush_w;

`ifdef SBOX_SCHED_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Capture slots trail issue slots by exactly LOOKUP_LAT cycles.
  if (LOOKUP_LAT == 0) begin : g_cap_direct
    assign cap_slot = lk_valid_q;
  end else begin : g_cap_delay
    logic [LOOKUP_LAT-1:0] vpipe_q, vpipe_d;
    logic [LOOKUP_LAT:0]   taps;

    assign taps     = {vpipe_q, lk_valid_q};
    assign vpipe_d  = flush_w ? '0 : taps[LOOKUP_LAT-1:0];
    assign cap_slot = taps[LOOKUP_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vpipe_q <= '0;
      end else begin
        vpipe_q <= vpipe_d;
      end
    end
  end

  assign cap_en = (state_q == StRun) && cap_slot;

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    res_d      = res_q;
    cap_d      = cap_q;
    lk_valid_d = 1'b0;
    lk_sel_d   = lk_sel_q;
    lk_addr_d  = lk_addr_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d    = StRun;
          // blk_q holds the not-yet-issued chunks, next one in [47:42].
          blk_d      = {in_data[41:0], 6'b0};
          res_d      = '0;
          cap_d      = '0;
          lk_valid_d = 1'b1;
          lk_sel_d   = 3'd0;
          lk_addr_d  = in_data[47:42];
        end
      end
      StRun: begin
        if (lk_valid_q && (lk_sel_q != 3'd7)) begin
          lk_valid_d = 1'b1;
          lk_sel_d   = lk_sel_q + 3'd1;
          lk_addr_d  = blk_q[47:42];
          blk_d      = {blk_q[41:0], 6'b0};
        end
        if (cap_en) begin
          res_d = {res_q[27:0], lk_data};
          cap_d = cap_q + 3'd1;
          if (cap_q == 3'd7) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort keeps the last result and lookup operands visible.
    if (flush_w) begin
      state_d    = StIdle;
      blk_d      = blk_q;
      res_d      = res_q;
      cap_d      = '0;
      lk_valid_d = 1'b0;
      lk_sel_d   = lk_sel_q;
      lk_addr_d  = lk_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      blk_q      <= '0;
      res_q      <= '0;
      cap_q      <= '0;
      lk_valid_q <= 1'b0;
      lk_sel_q   <= '0;
      lk_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      res_q      <= res_d;
      cap_q      <= cap_d;
      lk_valid_q <= lk_valid_d;
      lk_sel_q   <= lk_sel_d;
      lk_addr_q  <= lk_addr_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !flush_w;
  assign lk_valid  = lk_valid_q;
  assign lk_sel    = lk_sel_q;
  assign lk_addr   = lk_addr_q;
  assign out_valid = (state_q == StDone);
  assign out_data  = res_q;
  assign busy      = (state_q != StIdle);

endmodule
